seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  Downstream consumer of clockdivider: drives a 4-digit, common-anode, multiplexed 7-segment display
//   showing the calculator result.
//  Takes the divider's slow square wave as a scan-rate input and synchronises it into the system
//   clock domain, where it becomes a one-cycle scan enable.
//  Converts the binary result to BCD with a sequential double-dabble engine.
//  Applies leading-zero blanking, minus sign and overflow indication.
// PARAMETERS
//  VAL_W        14   width of the unsigned magnitude input (max displayable 9999)
//  SYNC_STAGES  2    flops in the scan_clk synchroniser (min 2)
// PORTS
//  in       input   1      system clock (same clock that feeds clockdivider)
//  rst      input   1      asynchronous, active-low reset
//  scan_clk input   1      clockdivider output; slow square wave, asynchronous to in
//  value    input   VAL_W  result magnitude, sampled when valid=1 and busy=0
//  neg      input   1      result sign, sampled with value
//  valid    input   1      load strobe, one or more cycles
//  busy     output  1      conversion in progress; valid ignored while high
//  seg      output  7      {g,f,e,d,c,b,a}, active low
//  an       output  4      digit anodes, active low, an[0] = rightmost digit
//  dp       output  1      decimal point, active low; held 1 (off)
// BEHAVIOUR
//  Reset (rst=0, async):
//   - an=4'b1111, seg=7'h7F, dp=1, busy=0.
//   - Display register = value 0, positive. Scan index = 0. FSM = IDLE.
//  Scan enable:
//   - scan_clk passes through SYNC_STAGES flops plus one history flop.
//   - scan_en = sync & ~hist: one in-cycle pulse per scan_clk rising edge.
//  Scan:
//   - On scan_en, idx <= idx+1 (wraps 3->0).
//   - an and seg register together for the new idx: an = ~(4'b0001<<idx).
//   - Outputs are glitch-free and change only on scan_en.
//  FSM states IDLE, SHIFT, DONE:
//   - IDLE: valid=1 -> capture value, neg; shift count = VAL_W; busy=1; -> SHIFT.
//   - SHIFT: one double-dabble iteration per cycle (add 3 to each BCD nibble >=5, then shift left 1);
//     after VAL_W iterations -> DONE.
//   - DONE: latch BCD, neg and ovf into the display register; busy=0; -> IDLE.
//   - Latency: valid to display register = VAL_W+2 cycles (16 at default).
//   - Displayed from the next scan_en. The old value is shown until then.
//  Overflow:
//   - ovf=1 if value>9999, or neg=1 and value>999.
//   - ovf: all four digits show '-' (7'b0111111).
//  Blanking:
//   - Digits above the most significant non-zero digit are blank (7'h7F).
//   - Digit 0 is never blanked, so value 0 shows "   0".
//  Sign:
//   - neg=1 and no ovf: '-' in the digit directly left of the MSD.
//   - -0 displays as "   0" (no sign).
//  Encoding (active low):
//   - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex, seg[6:0]).
//  Simultaneous events:
//   - scan_en during DONE: the scan uses the new display register value in the same cycle it is
//     written (write-first).
//   - valid in the same cycle as DONE is ignored (busy still 1).
//  Reset mid-conversion: abort, return to reset state; no partial value is ever displayed.
//  scan_clk stuck (divider held in reset): an/seg hold their last value; conversion is unaffected.
// STRUCTURE
//  seg7_defs.vh:
//   - segment constants SEG_0..SEG_9, SEG_BLANK, SEG_MINUS.
//   - FSM state localparams.
//   - DIGITS=4.
//  Sub-module bin2bcd_seq (VAL_W):
//   - Ports: in, rst, start, bin, busy, done, bcd[15:0].
//   - Holds the SHIFT loop. Top holds the synchroniser, overflow/blank/sign logic, the display
//     register and the scan mux.
// TESTING
//  Bench clocking: in at 50 MHz (#10 toggle); scan_clk from a real clockdivider instance, or a fast
//   model of it.
//  Reset then release, no valid:
//   - an=1111 and seg=7F before the first scan_en.
//   - Then digit 0 shows 40 and digits 1-3 show 7F.
//  value=1234, neg=0, one-cycle valid:
//   - busy high exactly 15 cycles.
//   - Over the next 4 scans, an 1110/1101/1011/0111 show 19/30/24/79.
//  value=7, neg=1:
//   - Digits 3..0 = 7F, 7F, 3F, 78.
//  value=1000, neg=1, and separately value=12000:
//   - All four digits show 3F.
//  valid pulsed while busy, with a different value:
//   - Ignored; the first value is displayed.
//  rst asserted mid-SHIFT:
//   - Outputs go to reset values immediately (async).
//   - After release the display shows 0, not the aborted value.

Source files
------------

// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment display:
// active-low segment codes, conversion FSM states and the digit decoder.
package seg7_scan_display_pkg;

    localparam int unsigned DIGITS = 4;

    // {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_of_digit = SEG_0;
            4'd1:    seg_of_digit = SEG_1;
            4'd2:    seg_of_digit = SEG_2;
            4'd3:    seg_of_digit = SEG_3;
            4'd4:    seg_of_digit = SEG_4;
            4'd5:    seg_of_digit = SEG_5;
            4'd6:    seg_of_digit = SEG_6;
            4'd7:    seg_of_digit = SEG_7;
            4'd8:    seg_of_digit = SEG_8;
            4'd9:    seg_of_digit = SEG_9;
            default: seg_of_digit = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// VAL_W iterations, then a one-cycle DONE with the 4-digit BCD result.
module bin2bcd_seq
    import seg7_scan_display_pkg::*;
#(
    parameter int unsigned VAL_W = 14
) (
    input  logic             in,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam int unsigned CNT_W = $clog2(VAL_W + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [VAL_W-1:0]   r_bin;
    logic [15:0]        r_bcd;
    logic [15:0]        w_adj;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge in or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin <= bin;
                        r_bcd <= '0;
                        r_cnt <= CNT_W'(VAL_W);
                    end
                end
                ST_SHIFT: begin
                    // Digits shifted out of the top nibble only matter above 9999,
                    // which the top flags as overflow independently.
                    {r_bcd, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign bcd  = r_bcd;

endmodule

// File: rtl/seg7_scan_display.sv
// 4-digit common-anode 7-segment scanner: synchronised scan strobe, BCD display
// register with overflow/sign/leading-zero blanking, registered anode/segment mux.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int unsigned VAL_W       = 14,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             in,
    input  logic             rst,
    input  logic             scan_clk,
    input  logic [VAL_W-1:0] value,
    input  logic             neg,
    input  logic             valid,
    output logic             busy,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             dp
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_scan_en;
    logic                   w_busy;
    logic                   w_done;
    logic [15:0]            w_bcd;
    logic                   w_ovf;
    logic                   r_cap_neg;
    logic                   r_cap_ovf;
    logic [15:0]            r_bcd;
    logic                   r_neg;
    logic                   r_ovf;
    logic [15:0]            w_disp_bcd;
    logic                   w_disp_neg;
    logic                   w_disp_ovf;
    logic [1:0]             r_idx;
    logic [1:0]             w_idx_nxt;
    logic [1:0]             w_msd;
    logic [6:0]             w_seg_nxt;

    bin2bcd_seq #(.VAL_W(VAL_W)) u_bin2bcd (
        .in    (in),
        .rst   (rst),
        .start (valid),
        .bin   (value),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    assign w_ovf = (32'(value) > 32'd9999) || (neg && (32'(value) > 32'd999));

    always_ff @(posedge in or negedge rst) begin
        if (!rst) begin
            r_sync    <= '0;
            r_hist    <= 1'b0;
            r_cap_neg <= 1'b0;
            r_cap_ovf <= 1'b0;
            r_bcd     <= '0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], scan_clk};
            r_hist <= r_sync[SYNC_STAGES-1];
            if (valid && !w_busy) begin
                r_cap_neg <= neg;
                r_cap_ovf <= w_ovf;
            end
            if (w_done) begin
                r_bcd <= w_bcd;
                r_neg <= r_cap_neg;
                r_ovf <= r_cap_ovf;
            end
        end
    end

    assign w_scan_en = r_sync[SYNC_STAGES-1] & ~r_hist;

    // Bypass so a scan in the DONE cycle already shows the value being written.
    assign w_disp_bcd = w_done ? w_bcd     : r_bcd;
    assign w_disp_neg = w_done ? r_cap_neg : r_neg;
    assign w_disp_ovf = w_done ? r_cap_ovf : r_ovf;
    assign w_idx_nxt  = r_idx + 2'd1;

    always_comb begin
        w_msd = '0;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            if (w_disp_bcd[i*4 +: 4] != 4'd0) w_msd = 2'(i);
        end
        w_seg_nxt = SEG_BLANK;
        if (w_disp_ovf)
            w_seg_nxt = SEG_MINUS;
        else if (w_idx_nxt <= w_msd || w_idx_nxt == 2'd0)
            w_seg_nxt = seg_of_digit(w_disp_bcd[w_idx_nxt*4 +: 4]);
        else if (w_disp_neg && (w_disp_bcd != '0) && ({1'b0, w_idx_nxt} == {1'b0, w_msd} + 3'd1))
            w_seg_nxt = SEG_MINUS;
    end

    always_ff @(posedge in or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
            an    <= '1;
            seg   <= SEG_BLANK;
        end else if (w_scan_en) begin
            r_idx <= w_idx_nxt;
            an    <= ~(4'b0001 << w_idx_nxt);
            seg   <= w_seg_nxt;
        end
    end

    assign busy = w_busy;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench: each scan pulse pushes the expected {an,seg}; a monitor
// pops and compares whenever the anode pattern changes.
module tb_seg7_scan_display;

    logic        clk;
    logic        rst_n;
    logic        scan_clk;
    logic [13:0] value;
    logic        neg;
    logic        valid;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int n_cmp  = 0;
    int n_fail = 0;
    int bidx   = 0;
    logic [10:0] q[$];

    typedef struct {
        logic [13:0] v;
        logic        n;
        logic [27:0] e;
    } vec_t;
    vec_t vecs[9];

    seg7_scan_display #(.VAL_W(14), .SYNC_STAGES(2)) dut (
        .in       (clk),
        .rst      (rst_n),
        .scan_clk (scan_clk),
        .value    (value),
        .neg      (neg),
        .valid    (valid),
        .busy     (busy),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [27:0] mk(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        mk = {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic scan_pulse(input logic [27:0] e);
        logic [3:0] a;
        bidx = (bidx + 1) % 4;
        a = ~(4'b0001 << bidx);
        q.push_back({a, e[bidx*7 +: 7]});
        @(negedge clk) scan_clk = 1'b1;
        repeat (6) @(negedge clk);
        scan_clk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic scan4(input logic [27:0] e);
        for (int k = 0; k < 4; k++) scan_pulse(e);
    endtask

    task automatic load(input logic [13:0] v, input logic n);
        int cnt;
        @(negedge clk);
        value = v; neg = n; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", cnt, 15);
    endtask

    // Monitor
    initial begin
        logic [3:0]  prev_an;
        logic [10:0] exp;
        prev_an = 4'hF;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_an = 4'hF;
            end else if (an !== prev_an) begin
                prev_an = an;
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_scan: got an=%b seg=%h with nothing expected", an, seg);
                end else begin
                    exp = q.pop_front();
                    if ({an, seg} !== exp) begin
                        n_fail++;
                        $display("FAIL scan: got an=%b seg=%h expected an=%b seg=%h",
                                 an, seg, exp[10:7], exp[6:0]);
                    end
                end
            end
        end
    end

    initial begin
        vecs[0] = '{14'd1234,  1'b0, mk(7'h79, 7'h24, 7'h30, 7'h19)};
        vecs[1] = '{14'd7,     1'b1, mk(7'h7F, 7'h7F, 7'h3F, 7'h78)};
        vecs[2] = '{14'd1000,  1'b1, mk(7'h3F, 7'h3F, 7'h3F, 7'h3F)};
        vecs[3] = '{14'd12000, 1'b0, mk(7'h3F, 7'h3F, 7'h3F, 7'h3F)};
        vecs[4] = '{14'd9999,  1'b0, mk(7'h10, 7'h10, 7'h10, 7'h10)};
        vecs[5] = '{14'd999,   1'b1, mk(7'h3F, 7'h10, 7'h10, 7'h10)};
        vecs[6] = '{14'd0,     1'b1, mk(7'h7F, 7'h7F, 7'h7F, 7'h40)};
        vecs[7] = '{14'd10000, 1'b0, mk(7'h3F, 7'h3F, 7'h3F, 7'h3F)};
        vecs[8] = '{14'd50,    1'b0, mk(7'h7F, 7'h7F, 7'h12, 7'h40)};

        rst_n = 1'b0; scan_clk = 1'b0; value = '0; neg = 1'b0; valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_an", int'(an), 'hF);
        chk("reset_seg", int'(seg), 'h7F);
        chk("reset_dp", int'(dp), 1);
        chk("reset_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("idle_an_before_scan", int'(an), 'hF);
        chk("idle_seg_before_scan", int'(seg), 'h7F);

        scan4(mk(7'h7F, 7'h7F, 7'h7F, 7'h40));

        foreach (vecs[i]) begin
            load(vecs[i].v, vecs[i].n);
            scan4(vecs[i].e);
        end

        // valid pulsed while busy must be ignored
        @(negedge clk);
        value = 14'd5678; neg = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        value = 14'd4321; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("busy_after_ignored_valid", int'(busy), 0);
        scan4(mk(7'h12, 7'h02, 7'h78, 7'h00));

        // reset in the middle of a conversion
        @(negedge clk);
        value = 14'd9999; neg = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_an", int'(an), 'hF);
        chk("midreset_seg", int'(seg), 'h7F);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_dp", int'(dp), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bidx = 0;
        repeat (20) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_an", int'(an), 'hF);
        scan4(mk(7'h7F, 7'h7F, 7'h7F, 7'h40));

        repeat (10) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL missing_scans: got %0d outstanding expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
